// File: rtl/vga_stream_timing.sv
// Video raster timing generator with a valid/ready pixel sink that locks an SOF-marked stream to the raster.
// Optional VGA_TESTPATTERN_EN: colour bars on active pixels whenever the stream is not locked.
module vga_stream_timing #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29,
  parameter int PIX_W  = 24,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int CNT_W  = 16
) (
  input  logic             pixel_clk,
  input  logic             pixel_rst_n,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_sof,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             HS,
  output logic             VS,
  output logic             BLANK,
  output logic [PIX_W-1:0] RGB,
  output logic             locked,
  output logic [CNT_W-1:0] underflow_cnt
);

  // state      | meaning
  // SEARCH     | draining the stream until an SOF pixel is offered
  // WAIT_FRAME | SOF held upstream, waiting for the raster's first active pixel
  // LOCKED     | stream aligned, one pixel consumed per active cycle
  typedef enum logic [1:0] {SEARCH, WAIT_FRAME, LOCKED} state_t;

  localparam int H  = HDISP + HFP + HPULSE + HBP;
  localparam int V  = VDISP + VFP + VPULSE + VBP;
  localparam int HW = $clog2(H);
  localparam int VW = $clog2(V);

  localparam logic [HW-1:0] H_LAST = HW'(H - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H - HDISP);
  localparam logic [HW-1:0] H_S0   = HW'(HFP);
  localparam logic [HW-1:0] H_S1   = HW'(HFP + HPULSE);
  localparam logic [VW-1:0] V_LAST = VW'(V - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V - VDISP);
  localparam logic [VW-1:0] V_S0   = VW'(VFP);
  localparam logic [VW-1:0] V_S1   = VW'(VFP + VPULSE);

  state_t           state, state_nxt;
  logic [HW-1:0]    h_cnt;
  logic [VW-1:0]    v_cnt;
  logic             active, fap, hs_win, vs_win;
  logic             ready_c, show, resync;
  logic [PIX_W-1:0] rgb_nxt;
  logic [PIX_W-1:0] idle_pix;

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign active = (h_cnt >= H_ACT) && (v_cnt >= V_ACT);
  assign fap    = (h_cnt == H_ACT) && (v_cnt == V_ACT);
  assign hs_win = (h_cnt >= H_S0) && (h_cnt < H_S1);
  assign vs_win = (v_cnt >= V_S0) && (v_cnt < V_S1);

`ifdef VGA_TESTPATTERN_EN
  localparam int CW = PIX_W / 3;
  logic [2:0] bar;

  always_comb begin
    // only meaningful on active pixels, where h_cnt >= H_ACT
    bar = 3'(((int'(h_cnt) - (H - HDISP)) * 8) / HDISP);
    idle_pix = '0;
    idle_pix[PIX_W-1 -: CW]        = {CW{bar[2]}};
    idle_pix[PIX_W-1-CW -: CW]     = {CW{bar[1]}};
    idle_pix[PIX_W-1-2*CW -: CW]   = {CW{bar[0]}};
  end
`else
  assign idle_pix = '0;
`endif

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    show      = 1'b0;
    resync    = 1'b0;
    case (state)
      SEARCH: begin
        ready_c = ~(s_valid & s_sof);
        if (s_valid && s_sof) state_nxt = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (fap && s_valid) begin
          if (s_sof) begin
            ready_c   = 1'b1;
            show      = 1'b1;
            state_nxt = LOCKED;
          end else begin
            state_nxt = SEARCH;
          end
        end
      end
      LOCKED: begin
        if (active) begin
          // SOF is only legal exactly on the first active pixel
          if (!s_valid) begin
            ready_c   = 1'b1;
            resync    = 1'b1;
            state_nxt = SEARCH;
          end else if (s_sof != fap) begin
            resync    = 1'b1;
            state_nxt = SEARCH;
          end else begin
            ready_c = 1'b1;
            show    = 1'b1;
          end
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    rgb_nxt = '0;
    if (show) rgb_nxt = s_data;
    else if (active && (state != LOCKED)) rgb_nxt = idle_pix;
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      state         <= SEARCH;
      HS            <= ~HS_POL;
      VS            <= ~VS_POL;
      BLANK         <= 1'b0;
      RGB           <= '0;
      underflow_cnt <= '0;
    end else begin
      state <= state_nxt;
      HS    <= hs_win ? HS_POL : ~HS_POL;
      VS    <= vs_win ? VS_POL : ~VS_POL;
      BLANK <= active;
      RGB   <= rgb_nxt;
      if (resync && (underflow_cnt != '1)) underflow_cnt <= underflow_cnt + 1'b1;
    end
  end

  assign locked  = (state == LOCKED);
  assign s_ready = ready_c & pixel_rst_n;

endmodule

// File: tb/tb_vga_stream_timing.sv
// Self-checking bench for vga_stream_timing on a 7x6 raster: per-cycle reference model plus literal checks.
module tb_vga_stream_timing;

  localparam int HDISP = 4, HFP = 1, HPULSE = 1, HBP = 1;
  localparam int VDISP = 3, VFP = 1, VPULSE = 1, VBP = 1;
  localparam int PIX_W = 24, CNT_W = 2;
  localparam bit HS_POL = 1'b0, VS_POL = 1'b0;
  localparam int H = HDISP + HFP + HPULSE + HBP;
  localparam int V = VDISP + VFP + VPULSE + VBP;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             pixel_clk = 1'b0;
  logic             pixel_rst_n = 1'b1;
  logic [PIX_W-1:0] s_data = '0;
  logic             s_sof = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready, HS, VS, BLANK, locked;
  logic [PIX_W-1:0] RGB;
  logic [CNT_W-1:0] underflow_cnt;

  vga_stream_timing #(
    .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .PIX_W(PIX_W),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .CNT_W(CNT_W)
  ) dut (
    .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n),
    .s_data(s_data), .s_sof(s_sof), .s_valid(s_valid), .s_ready(s_ready),
    .HS(HS), .VS(VS), .BLANK(BLANK), .RGB(RGB),
    .locked(locked), .underflow_cnt(underflow_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: tcnt is the number of clock edges since reset, raster position is derived by division.
  typedef struct {
    int          tcnt;
    int          cnt;
    bit          lck;
    bit          armed;
    bit          hs;
    bit          vs;
    bit          blank;
    logic [23:0] rgb;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.tcnt = 0; r.cnt = 0; r.lck = 1'b0; r.armed = 1'b0;
    r.hs = !HS_POL; r.vs = !VS_POL; r.blank = 1'b0; r.rgb = '0;
    return r;
  endfunction

  function automatic bit is_act(input int t);
    int h = t % H;
    int v = (t / H) % V;
    return (h >= H - HDISP) && (v >= V - VDISP);
  endfunction

  function automatic bit is_fap(input int t);
    return ((t % H) == H - HDISP) && (((t / H) % V) == V - VDISP);
  endfunction

  function automatic logic [23:0] idle_colour(input int h);
    logic [23:0] c = '0;
`ifdef VGA_TESTPATTERN_EN
    int b = ((h - (H - HDISP)) * 8) / HDISP;
    if (b[2]) c = c | 24'hFF0000;
    if (b[1]) c = c | 24'h00FF00;
    if (b[0]) c = c | 24'h0000FF;
`endif
    return c;
  endfunction

  function automatic model_t model_next(input model_t c, input logic vld, input logic sof, input logic [23:0] d);
    model_t n = c;
    int h = c.tcnt % H;
    int v = (c.tcnt / H) % V;
    bit act = is_act(c.tcnt);
    bit fap = is_fap(c.tcnt);
    n.tcnt  = c.tcnt + 1;
    n.hs    = (h >= HFP && h < HFP + HPULSE) ? HS_POL : !HS_POL;
    n.vs    = (v >= VFP && v < VFP + VPULSE) ? VS_POL : !VS_POL;
    n.blank = act;
    n.rgb   = '0;
    if (c.lck) begin
      if (act) begin
        if (vld && (sof == fap)) n.rgb = d;
        else begin
          n.cnt = (c.cnt < CNT_MAX) ? c.cnt + 1 : c.cnt;
          n.lck = 1'b0;
        end
      end
    end else begin
      if (act) n.rgb = idle_colour(h);
      if (c.armed && fap && vld) begin
        n.armed = 1'b0;
        if (sof) begin
          n.lck = 1'b1;
          n.rgb = d;
        end
      end else if (!c.armed && vld && sof) begin
        n.armed = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic bit exp_ready();
    bit act = is_act(m.tcnt);
    bit fap = is_fap(m.tcnt);
    if (!pixel_rst_n) return 1'b0;
    if (m.lck) return act && !(s_valid && (s_sof != fap));
    if (m.armed) return fap && s_valid && s_sof;
    return !(s_valid && s_sof);
  endfunction

  always @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) m <= model_reset();
    else m <= model_next(m, s_valid, s_sof, s_data);
  end

  always @(negedge pixel_clk) begin
    chk("HS", HS, m.hs);
    chk("VS", VS, m.vs);
    chk("BLANK", BLANK, m.blank);
    chk("RGB", RGB, m.rgb);
    chk("locked", locked, m.lck);
    chk("underflow_cnt", underflow_cnt, m.cnt);
    chk("s_ready", s_ready, exp_ready());
  end

  // Captures displayed pixels during the continuous-stream phase.
  bit          obs_en = 1'b0;
  logic [31:0] rgbq[$];
  bit          lkq[$];
  bit          prev_locked = 1'b0;
  int          first_prev = -1;

  always @(negedge pixel_clk) begin
    if (obs_en) begin
      if (BLANK) begin
        if (rgbq.size() == 0) first_prev <= int'(prev_locked);
        rgbq.push_back(32'(RGB));
        lkq.push_back(locked);
      end
      prev_locked <= locked;
    end
  end

  // Stream source: frames of 12 pixels, data = index 1..12, SOF on index 1.
  bit src_on = 1'b0;
  int src_idx = 1;
  int drop_at = 0;
  int drop_left = 0;
  bit mis_en = 1'b0;

  task automatic cyc();
    bit inj, dn, acc;
    inj = 1'b0;
    if (mis_en && src_on && src_idx == 3 && m.lck) begin
      src_idx = 1;
      mis_en = 1'b0;
      inj = 1'b1;
    end
    dn = (drop_left > 0) && src_on && (src_idx == drop_at) && m.lck && is_act(m.tcnt);
    s_valid = src_on && !dn;
    s_sof   = (src_idx == 1);
    s_data  = 24'(src_idx);
    @(negedge pixel_clk);
    if (inj) chk("s_ready_held_on_misaligned_sof", s_ready, 1'b0);
    acc = s_valid && exp_ready();
    @(posedge pixel_clk);
    #1;
    if (dn) drop_left--;
    if (acc) src_idx = (src_idx == 12) ? 1 : src_idx + 1;
  endtask

  int hs_low, vs_low, blank_hi, np;
  logic [23:0] bars[4];
  logic [23:0] bar_exp[4];

  initial begin
    #1 pixel_rst_n = 1'b0;
    repeat (2) @(negedge pixel_clk);
    chk("reset_HS", HS, 1'b1);
    chk("reset_VS", VS, 1'b1);
    chk("reset_BLANK", BLANK, 1'b0);
    chk("reset_s_ready", s_ready, 1'b0);
    @(posedge pixel_clk);
    #1 pixel_rst_n = 1'b1;

    // free-run, no stream
    hs_low = 0; vs_low = 0; blank_hi = 0; np = 0;
    for (int i = 0; i < 85; i++) begin
      @(negedge pixel_clk);
      if (!HS) hs_low++;
      if (!VS) vs_low++;
      if (BLANK) begin
        blank_hi++;
        if (np < 4) begin
          bars[np] = RGB;
          np++;
        end
      end
    end
    chk("freerun_hs_low_cycles", hs_low, 12);
    chk("freerun_vs_low_cycles", vs_low, 14);
    chk("freerun_blank_cycles", blank_hi, 24);
`ifdef VGA_TESTPATTERN_EN
    bar_exp[0] = 24'h000000; bar_exp[1] = 24'h00FF00;
    bar_exp[2] = 24'hFF0000; bar_exp[3] = 24'hFFFF00;
`else
    for (int i = 0; i < 4; i++) bar_exp[i] = 24'h000000;
`endif
    for (int i = 0; i < 4; i++) chk("unlocked_first_line_rgb", bars[i], bar_exp[i]);
    @(posedge pixel_clk);
    #1;

    // continuous stream, two locked frames
    src_on = 1'b1;
    src_idx = 1;
    obs_en = 1'b1;
    repeat (100) cyc();
    obs_en = 1'b0;
    chk("stream_pixel_count", rgbq.size(), 24);
    for (int i = 0; i < rgbq.size() && i < 24; i++) begin
      chk("stream_rgb", rgbq[i], (i % 12) + 1);
      chk("stream_locked", lkq[i], 1'b1);
    end
    chk("locked_low_at_fap", first_prev, 0);

    // one-cycle underflow on pixel 5, then re-lock next frame
    drop_at = 5;
    drop_left = 1;
    repeat (85) cyc();
    chk("underflow_count_after_drop", underflow_cnt, 1);
    chk("relocked_after_drop", locked, 1'b1);

    // asynchronous reset between clock edges
    #2 pixel_rst_n = 1'b0;
    src_on = 1'b0;
    src_idx = 1;
    s_valid = 1'b0;
    #1;
    chk("async_rst_HS", HS, 1'b1);
    chk("async_rst_VS", VS, 1'b1);
    chk("async_rst_BLANK", BLANK, 1'b0);
    chk("async_rst_RGB", RGB, 0);
    chk("async_rst_locked", locked, 1'b0);
    chk("async_rst_cnt", underflow_cnt, 0);
    chk("async_rst_s_ready", s_ready, 1'b0);
    repeat (2) @(posedge pixel_clk);
    #1 pixel_rst_n = 1'b1;
    @(negedge pixel_clk);
    chk("restart_hs_t0", HS, 1'b1);
    @(negedge pixel_clk);
    chk("restart_hs_h0", HS, 1'b1);
    @(negedge pixel_clk);
    chk("restart_hs_h1", HS, 1'b0);
    @(posedge pixel_clk);
    #1;

    // SOF offered on pixel 3 of a locked frame
    src_on = 1'b1;
    mis_en = 1'b1;
    repeat (40) cyc();
    chk("misalign_count", underflow_cnt, 1);
    chk("misalign_unlocked", locked, 1'b0);
    repeat (50) cyc();
    chk("relocked_after_misalign", locked, 1'b1);

    // repeated underflows saturate the counter
    drop_at = 2;
    drop_left = 100;
    repeat (200) cyc();
    chk("underflow_saturated", underflow_cnt, CNT_MAX);
    drop_left = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_stream_timing.md
Name: vga_stream_timing

Overview:
Parametrised single-clock video timing generator with a valid/ready pixel-stream sink. It is the successor to the FIFO-fed VGA controller.
- Generates HS/VS/BLANK with configurable porches, pulse polarity and pixel width.
- Locks an upstream frame stream to the raster using a start-of-frame flag.
- Detects underflow and misalignment, then resynchronises automatically.
- Sits between the framebuffer reader's output FIFO (pixel_clk side) and the video_if pins.

Parameters:
HDISP, 800, active pixels per line
VDISP, 480, active lines per frame
HFP, 40, horizontal front porch (pixels)
HPULSE, 48, horizontal sync pulse width
HBP, 40, horizontal back porch
VFP, 13, vertical front porch (lines)
VPULSE, 3, vertical sync pulse width
VBP, 29, vertical back porch
PIX_W, 24, pixel data width
HS_POL, 0, HS active level (0 = active-low)
VS_POL, 0, VS active level
CNT_W, 16, underflow counter width

Ports:
pixel_clk  in  1  sole clock
pixel_rst_n  in  1  asynchronous active-low reset
s_data  in  PIX_W  upstream pixel
s_sof  in  1  marks first pixel of a frame
s_valid  in  1  s_data/s_sof valid
s_ready  out  1  pixel accepted when s_valid & s_ready
HS  out  1  horizontal sync
VS  out  1  vertical sync
BLANK  out  1  high during active display area
RGB  out  PIX_W  displayed pixel
locked  out  1  stream aligned to raster
underflow_cnt  out  CNT_W  saturating count of resync events

Behaviour:
- Reset is asynchronous and active-low: pixel_rst_n low clears all state immediately, independent of pixel_clk.
- H = HDISP+HFP+HPULSE+HBP and V = VDISP+VFP+VPULSE+VBP.
- Counters:
  - h counts 0..H-1 and wraps to 0.
  - v increments when h==H-1 and wraps to 0 after V-1.
  - Both reset to 0.
- Line/frame order:
  - Horizontal: front porch, sync, back porch, active. Sync is asserted for HFP<=h<HFP+HPULSE.
  - Vertical uses the same order with VFP/VPULSE.
  - active = (h>=H-HDISP) && (v>=V-VDISP).
  - First active pixel (FAP) = h==H-HDISP && v==V-VDISP.
- Outputs:
  - HS, VS, BLANK and RGB are registered and lag the counters by exactly 1 cycle, all mutually aligned.
  - HS output level is HS_POL when in sync and ~HS_POL otherwise; VS likewise with VS_POL.
- Reset values:
  - HS=~HS_POL, VS=~VS_POL.
  - BLANK=0, RGB=0, locked=0, underflow_cnt=0.
  - State = SEARCH; s_ready=0 while reset is asserted.
- State machine:
  - SEARCH:
    - s_ready = ~(s_valid & s_sof), i.e. non-SOF pixels are drained and discarded.
    - On s_valid & s_sof -> WAIT_FRAME. The SOF pixel is not consumed.
  - WAIT_FRAME:
    - s_ready=0.
    - At the FAP cycle, if s_valid & s_sof -> LOCKED and the pixel is consumed.
    - At the FAP cycle, if !s_valid -> stay in WAIT_FRAME for the next frame; no count.
  - LOCKED:
    - s_ready = active; locked=1.
    - Each active cycle with s_valid & !s_sof consumes the pixel, and RGB <= s_data on the next cycle.
    - Active cycle with !s_valid -> underflow: RGB <= 0, underflow_cnt++, -> SEARCH.
    - Active cycle with s_valid & s_sof at a non-FAP position -> misalignment: pixel not consumed, underflow_cnt++, -> SEARCH.
    - FAP cycle with s_valid & !s_sof -> misalignment, handled the same way.
- RGB is 0 in every non-active cycle and in every active cycle when the state is not LOCKED.
- underflow_cnt saturates at 2^CNT_W-1.
- s_ready is combinational from state, counters and s_valid/s_sof, with no s_data path. Upstream must hold s_data/s_sof while s_valid & !s_ready.
- Simultaneous events: if the underflow and wrap conditions coincide at the last active pixel (h=H-1, v=V-1), both the counter wrap and the -> SEARCH transition occur in the same cycle.

Optional Feature:
VGA_TESTPATTERN_EN
- Defined: when not LOCKED, active pixels show 8 vertical colour bars instead of black.
  - Bar index = ((h-(H-HDISP))*8)/HDISP.
  - Colour bit i of the index drives the MSB-aligned all-ones field of R (bit 2), G (bit 1), B (bit 0).
  - Underflow cycles still output 0.
- Not defined: unlocked active pixels are 0; no extra logic is generated.

Test Plan:
Small configuration for all scenarios: HDISP=4, HFP=HPULSE=HBP=1, VDISP=3, VFP=VPULSE=VBP=1 (H=7, V=6, 42-cycle frame).
- Free-run, s_valid=0, 2 frames:
  - HS low for 1 cycle every 7, VS low for 7 cycles every 42.
  - BLANK high for 12 cycles per frame; RGB=0; locked=0; underflow_cnt=0.
- Continuous stream, s_sof on pixel 0, data=index 1..12:
  - locked rises 1 cycle after FAP; RGB shows 1..12 in raster order, aligned with BLANK.
  - Second frame repeats; underflow_cnt=0.
- Drop s_valid at active pixel 5 of a locked frame:
  - That pixel is RGB=0, underflow_cnt=1, locked falls.
  - Re-lock occurs at the next frame's FAP when SOF is presented.
- s_sof asserted on pixel 3 while locked: pixel held (s_ready=0), underflow_cnt=1, state SEARCH, then WAIT_FRAME.
- Assert pixel_rst_n low mid-line between clock edges:
  - Outputs reach reset values before the next pixel_clk edge.
  - After release the raster restarts at h=v=0.
- With VGA_TESTPATTERN_EN defined and unlocked:
  - Active pixels at h=3..6 show bar indices 0, 2, 4, 6, i.e. RGB 000000, 00FF00, FF0000, FFFF00.
